// File: rtl/qsys_multi_timer_if.sv
// Avalon-MM style slave bus for the multi-channel timer register file.
// ADDR_W must be $clog2(CHANNELS)+3 to match the timer instance.
interface qsys_multi_timer_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/qsys_multi_timer.sv
// Multi-channel down-counting timer with per-channel timeout interrupt.
// Define QSYS_MULTI_TIMER_PWM_EN to enable compare registers and pwm_out.
module qsys_multi_timer #(
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int PERIOD_RST = 9
) (
  input  logic                clk,
  input  logic                reset,
  qsys_multi_timer_if.slave   bus,
  output logic                irq,
  output logic [CHANNELS-1:0] pwm_out
);
  localparam int AW = $clog2(CHANNELS) + 3;
  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(PERIOD_RST);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] counter  [CHANNELS];
  logic [CNT_WIDTH-1:0] period   [CHANNELS];
  logic [CNT_WIDTH-1:0] snapshot [CHANNELS];
  logic [CHANNELS-1:0]  run, to, ito, cont, tmo, ch_irq;
  logic [CHANNELS-1:0]  wr_status, wr_control, wr_period, wr_snap;
  logic [AW-1:0]        ch_sel;
  logic [2:0]           reg_sel;
  logic                 ch_ok, wr_en;
  logic [CNT_WIDTH-1:0] wdata;
  logic [31:0]          rd_next;
`ifdef QSYS_MULTI_TIMER_PWM_EN
  logic [CNT_WIDTH-1:0] compare [CHANNELS];
  logic [CHANNELS-1:0]  wr_compare;
`endif

  assign ch_sel  = bus.address >> 3;
  assign reg_sel = bus.address[2:0];
  assign ch_ok   = ch_sel < AW'(CHANNELS);
  assign wr_en   = bus.chipselect & ~bus.write_n & ch_ok;
  assign wdata   = bus.writedata[CNT_WIDTH-1:0];
  assign ch_irq  = to & ito;
  assign irq     = |ch_irq;

  // Write strobes and the read mux share one channel decode.
  always_comb begin
    tmo        = '0;
    wr_status  = '0;
    wr_control = '0;
    wr_period  = '0;
    wr_snap    = '0;
`ifdef QSYS_MULTI_TIMER_PWM_EN
    wr_compare = '0;
`endif
    rd_next    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tmo[i] = run[i] & (counter[i] == '0);
      if (ch_sel == AW'(i)) begin
        case (reg_sel)
          3'd0: begin
            wr_status[i] = wr_en;
            rd_next[1:0] = {run[i], to[i]};
          end
          3'd1: begin
            wr_control[i] = wr_en;
            rd_next[1:0]  = {cont[i], ito[i]};
          end
          3'd2: begin
            wr_period[i]             = wr_en;
            rd_next[CNT_WIDTH-1:0]   = period[i];
          end
          3'd3: begin
            wr_snap[i]               = wr_en;
            rd_next[CNT_WIDTH-1:0]   = snapshot[i];
          end
`ifdef QSYS_MULTI_TIMER_PWM_EN
          3'd4: begin
            wr_compare[i]            = wr_en;
            rd_next[CNT_WIDTH-1:0]   = compare[i];
          end
`endif
          3'd5: rd_next[CHANNELS-1:0] = ch_irq;
          default: rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.readdata <= '0;
      run          <= '0;
      to           <= '0;
      ito          <= '0;
      cont         <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        counter[i]  <= CNT_RST;
        period[i]   <= CNT_RST;
        snapshot[i] <= '0;
      end
    end else begin
      bus.readdata <= rd_next;
      for (int i = 0; i < CHANNELS; i++) begin
        if (run[i]) begin
          if (tmo[i]) begin
            counter[i] <= period[i];
            if (!cont[i]) run[i] <= 1'b0;
          end else begin
            counter[i] <= counter[i] - CNT_ONE;
          end
        end
        // A timeout landing on a status write keeps TO set.
        if (tmo[i])             to[i] <= 1'b1;
        else if (wr_status[i])  to[i] <= 1'b0;
        if (wr_control[i]) begin
          ito[i]  <= wdata[0];
          cont[i] <= wdata[1];
          if (wdata[3])      run[i] <= 1'b0;
          else if (wdata[2]) run[i] <= 1'b1;
        end
        if (wr_period[i]) begin
          period[i]  <= wdata;
          counter[i] <= wdata;
          run[i]     <= 1'b0;
        end
        if (wr_snap[i]) snapshot[i] <= counter[i];
      end
    end
  end

`ifdef QSYS_MULTI_TIMER_PWM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= '0;
      for (int i = 0; i < CHANNELS; i++) compare[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_compare[i]) compare[i] <= wdata;
        pwm_out[i] <= run[i] & (counter[i] < compare[i]);
      end
    end
  end
`else
  assign pwm_out = '0;
`endif

endmodule

// File: tb/tb_qsys_multi_timer.sv
// Self-checking bench for qsys_multi_timer: directed scenarios plus random
// register traffic compared against a per-channel behavioural model.
module tb_qsys_multi_timer;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int PR = 9;
  localparam int AW = $clog2(CH) + 3;
`ifdef QSYS_MULTI_TIMER_PWM_EN
  localparam bit PWM = 1'b1;
`else
  localparam bit PWM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          irq;
  logic [CH-1:0] pwm_out;

  qsys_multi_timer_if #(.ADDR_W(AW)) bus ();

  qsys_multi_timer #(.CHANNELS(CH), .CNT_WIDTH(CW), .PERIOD_RST(PR)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each channel holds after the latest edge.
  logic [31:0]   m_cnt  [CH];
  logic [31:0]   m_per  [CH];
  logic [31:0]   m_snap [CH];
  logic [31:0]   m_cmp  [CH];
  bit            m_ito  [CH];
  bit            m_cont [CH];
  bit            m_to   [CH];
  bit            m_run  [CH];
  logic [CH-1:0] m_pwm;
  logic [31:0]   m_rd;

  function automatic bit m_irq();
    bit v = 1'b0;
    for (int k = 0; k < CH; k++) v |= m_to[k] & m_ito[k];
    return v;
  endfunction

  function automatic logic [AW-1:0] adr(int ch, int r);
    return AW'(ch * 8 + r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = PR; m_per[k] = PR; m_snap[k] = 0; m_cmp[k] = 0;
      m_ito[k] = 0;  m_cont[k] = 0; m_to[k] = 0;   m_run[k] = 0;
    end
    m_pwm = '0;
    m_rd  = '0;
  endtask

  // One clock: sample the driven bus, advance the DUT and the model together.
  task automatic step();
    bit          wr, rst, tmo, wrk;
    int          c, r;
    logic [31:0] wd, rd, old_cnt;
    wr  = bus.chipselect && !bus.write_n;
    rst = reset;
    c   = int'(bus.address >> 3);
    r   = int'(bus.address[2:0]);
    wd  = bus.writedata;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rd = 0;
      if (c < CH) begin
        case (r)
          0: rd = {30'd0, m_run[c], m_to[c]};
          1: rd = {30'd0, m_cont[c], m_ito[c]};
          2: rd = m_per[c];
          3: rd = m_snap[c];
          4: rd = PWM ? m_cmp[c] : 32'd0;
          5: for (int k = 0; k < CH; k++) rd[k] = m_to[k] & m_ito[k];
          default: rd = 0;
        endcase
      end
      for (int k = 0; k < CH; k++) begin
        wrk      = wr && (c == k);
        old_cnt  = m_cnt[k];
        tmo      = m_run[k] && (m_cnt[k] == 0);
        m_pwm[k] = PWM && m_run[k] && (m_cnt[k] < m_cmp[k]);
        if (m_run[k]) begin
          if (tmo) begin
            m_cnt[k] = m_per[k];
            if (!m_cont[k]) m_run[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
        if (tmo) m_to[k] = 1;
        else if (wrk && r == 0) m_to[k] = 0;
        if (wrk) begin
          case (r)
            1: begin
              m_ito[k] = wd[0]; m_cont[k] = wd[1];
              if (wd[3]) m_run[k] = 0;
              else if (wd[2]) m_run[k] = 1;
            end
            2: begin m_per[k] = wd; m_cnt[k] = wd; m_run[k] = 0; end
            3: m_snap[k] = old_cnt;
            4: if (PWM) m_cmp[k] = wd;
            default: ;
          endcase
        end
      end
      m_rd = rd;
    end
    #1;
  endtask

  task automatic wr(int ch, int r, logic [31:0] data);
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    bus.address = adr(ch, r); bus.writedata = data;
    step();
  endtask

  task automatic idle(int ch, int r);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.address = adr(ch, r); bus.writedata = $urandom;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(0, 2); idle(0, 2);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %0h expected 0", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (pwm_out !== '0) begin errors++; $display("FAIL reset_pwm: got %b expected 0", pwm_out); end
    reset = 1'b0;
    idle(0, 2);
    checks++; if (bus.readdata !== 32'(PR)) begin errors++; $display("FAIL reset_period0: got %0d expected %0d", bus.readdata, PR); end
    idle(3, 2);
    checks++; if (bus.readdata !== 32'(PR)) begin errors++; $display("FAIL reset_period3: got %0d expected %0d", bus.readdata, PR); end
    idle(0, 1);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL reset_control: got %0h expected 0", bus.readdata); end
  endtask

  task automatic test_periodic();
    logic [31:0] exp_cnt;
    wr(0, 2, 32'd3);
    wr(0, 1, 32'h7);
    wr(0, 3, $urandom);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL periodic_snap_init: got %0d expected 0", bus.readdata); end
    for (int i = 0; i < 8; i++) begin
      wr(0, 3, $urandom);
      exp_cnt = 32'(3 - (i % 4));
      checks++; if (bus.readdata !== exp_cnt) begin errors++; $display("FAIL periodic_count[%0d]: got %0d expected %0d", i, bus.readdata, exp_cnt); end
      checks++; if (irq !== (i >= 2)) begin errors++; $display("FAIL periodic_irq[%0d]: got %b expected %b", i, irq, (i >= 2)); end
    end
    wr(0, 0, $urandom);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL periodic_irq_clear: got %b expected 0", irq); end
    wr(0, 1, 32'h8);
    wr(0, 0, 32'h0);
  endtask

  task automatic test_oneshot();
    wr(1, 2, 32'd2);
    wr(1, 1, 32'h4);
    for (int i = 0; i < 6; i++) idle(1, 0);
    checks++; if (bus.readdata !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %0h expected 1", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq: got %b expected 0", irq); end
    wr(1, 3, $urandom);
    idle(1, 3);
    checks++; if (bus.readdata !== 32'd2) begin errors++; $display("FAIL oneshot_hold: got %0d expected 2", bus.readdata); end
  endtask

  task automatic test_stop_wins();
    wr(2, 2, 32'd20);
    wr(2, 1, 32'h6);
    for (int i = 0; i < 3; i++) idle(2, 0);
    wr(2, 1, 32'hC);
    idle(2, 0);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL stop_status: got %0h expected 0", bus.readdata); end
    idle(2, 0);
    wr(2, 3, $urandom);
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL stop_snap_latency: got %0d expected 0", bus.readdata); end
    idle(2, 3);
    checks++; if (bus.readdata !== 32'd16) begin errors++; $display("FAIL stop_snap_frozen: got %0d expected 16", bus.readdata); end
  endtask

  task automatic test_collision();
    wr(0, 2, 32'd3);
    wr(0, 1, 32'h7);
    for (int i = 0; i < 3; i++) idle(0, 0);
    wr(0, 0, $urandom);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b expected 1", irq); end
    idle(0, 0);
    checks++; if (bus.readdata !== 32'h3) begin errors++; $display("FAIL collision_status: got %0h expected 3", bus.readdata); end
    idle(0, 5);
    checks++; if (bus.readdata !== 32'h1) begin errors++; $display("FAIL collision_pending: got %0h expected 1", bus.readdata); end
    idle(3, 2);
    checks++; if (bus.readdata !== 32'(PR)) begin errors++; $display("FAIL collision_ch3_period: got %0d expected %0d", bus.readdata, PR); end
    idle(3, 0);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL collision_ch3_status: got %0h expected 0", bus.readdata); end
    wr(0, 1, 32'h8);
    wr(0, 0, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collision_cleanup_irq: got %b expected 0", irq); end
  endtask

  task automatic test_pwm();
    int high = 0;
    wr(0, 2, 32'd9);
    wr(0, 4, 32'd5);
    wr(0, 1, 32'h6);
    for (int i = 0; i < 40; i++) begin
      idle(0, 4);
      high += int'(pwm_out[0]);
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL pwm_model[%0d]: got %b expected %b", i, pwm_out, m_pwm); end
    end
    checks++; if (high != (PWM ? 20 : 0)) begin errors++; $display("FAIL pwm_duty: got %0d expected %0d", high, (PWM ? 20 : 0)); end
    checks++; if (bus.readdata !== (PWM ? 32'd5 : 32'd0)) begin errors++; $display("FAIL pwm_compare_read: got %0d expected %0d", bus.readdata, (PWM ? 5 : 0)); end
    wr(0, 1, 32'h8);
  endtask

  task automatic test_reset_midcount();
    wr(0, 2, 32'd9);
    wr(0, 1, 32'h7);
    for (int i = 0; i < 3; i++) idle(0, 2);
    reset = 1'b1;
    idle(0, 2);
    reset = 1'b0;
    checks++; if (bus.readdata !== 32'd0) begin errors++; $display("FAIL midreset_readdata: got %0h expected 0", bus.readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
    checks++; if (pwm_out !== '0) begin errors++; $display("FAIL midreset_pwm: got %b expected 0", pwm_out); end
    wr(0, 3, $urandom);
    idle(0, 3);
    checks++; if (bus.readdata !== 32'(PR)) begin errors++; $display("FAIL midreset_counter: got %0d expected %0d", bus.readdata, PR); end
    idle(0, 0);
    checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL midreset_status: got %0h expected 0", bus.readdata); end
  endtask

  task automatic test_random();
    int c, r;
    logic [31:0] d;
    for (int i = 0; i < 400; i++) begin
      c = $urandom_range(0, CH - 1);
      r = $urandom_range(0, 7);
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) == 0) begin
        idle(c, r);
      end else begin
        if (r == 2)      d = $urandom_range(0, 12);
        else if (r == 1) d = $urandom_range(0, 15);
        else if (r == 4) d = $urandom_range(0, 14);
        else             d = $urandom;
        wr(c, r, d);
      end
      checks++; if (bus.readdata !== m_rd) begin errors++; $display("FAIL random_rd[%0d]: got %0h expected %0h", i, bus.readdata, m_rd); end
      checks++; if (irq !== m_irq()) begin errors++; $display("FAIL random_irq[%0d]: got %b expected %b", i, irq, m_irq()); end
      checks++; if (pwm_out !== m_pwm) begin errors++; $display("FAIL random_pwm[%0d]: got %b expected %b", i, pwm_out, m_pwm); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop_wins();
    test_collision();
    test_pwm();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
